// File: rtl/slc3_dp_pkg.sv
// Shared types and constants for the SLC-3 handshake datapath and its memory interface.
package slc3_dp_pkg;

  typedef enum logic [1:0] {PC_INC, PC_BUS, PC_ADDER, PC_HOLD} pcmux_t;
  typedef enum logic [1:0] {A2_ZERO, A2_OFF6, A2_OFF9, A2_OFF11} addr2mux_t;
  typedef enum logic [1:0] {ALU_ADD, ALU_AND, ALU_NOT, ALU_PASS} aluk_t;
  typedef enum logic [1:0] {IDLE, RD, WR, DONE} mem_state_t;

  localparam logic [2:0] CC_NEG  = 3'b100;
  localparam logic [2:0] CC_ZERO = 3'b010;
  localparam logic [2:0] CC_POS  = 3'b001;
  localparam logic [2:0] R7_IDX  = 3'd7;

endpackage

// File: rtl/slc3_mem_if.sv
// Memory req/ack handshake FSM with timeout abort and sticky error; strobes MDR capture on read ack.
module slc3_mem_if
  import slc3_dp_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic Clk,
  input  logic Reset,
  input  logic rd_start,
  input  logic wr_start,
  input  logic ack,
  output logic req,
  output logic we,
  output logic busy,
  output logic done,
  output logic err,
  output logic mdr_cap
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

  mem_state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic set_err;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state <= IDLE;
      cnt   <= '0;
      err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE)
        cnt <= '0;
      else if (state == RD || state == WR)
        cnt <= cnt + CNT_W'(1);
      if (set_err)
        err <= 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    set_err  = 1'b0;
    mdr_cap  = 1'b0;
    case (state)
      IDLE: begin
        // Simultaneous starts resolve to a read but are flagged as a control error.
        if (rd_start) begin
          state_nx = RD;
          set_err  = wr_start;
        end else if (wr_start) begin
          state_nx = WR;
        end
      end
      RD, WR: begin
        if (ack) begin
          mdr_cap  = (state == RD);
          state_nx = DONE;
        end else if (cnt == TO_LAST) begin
          set_err  = 1'b1;
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign req  = (state == RD) || (state == WR);
  assign we   = (state == WR);
  assign busy = req;
  assign done = (state == DONE);

endmodule

// File: rtl/slc3_datapath_hs.sv
// SLC-3 datapath (regfile, PC/IR/MAR/MDR, ALU, address adder, CC/BEN, LED) with handshake memory.
// Define SLC3_DP_PERF_EN to build the 32-bit fetched-instruction counter on 'retired'.
module slc3_datapath_hs
  import slc3_dp_pkg::*;
#(
  parameter int              DATA_W      = 16,
  parameter int              LED_W       = 12,
  parameter int              MEM_TIMEOUT = 15,
  parameter logic [DATA_W-1:0] PC_RESET  = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LD_MAR,
  input  logic              LD_MDR,
  input  logic              LD_IR,
  input  logic              LD_BEN,
  input  logic              LD_CC,
  input  logic              LD_REG,
  input  logic              LD_PC,
  input  logic              LD_LED,
  input  logic              GatePC,
  input  logic              GateMDR,
  input  logic              GateALU,
  input  logic              GateMARMUX,
  input  logic              SR2MUX,
  input  logic              ADDR1MUX,
  input  logic              MARMUX,
  input  logic              DRMUX,
  input  logic              SR1MUX,
  input  logic [1:0]        PCMUX,
  input  logic [1:0]        ADDR2MUX,
  input  logic [1:0]        ALUK,
  input  logic              mem_rd_start,
  input  logic              mem_wr_start,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic              mem_busy,
  output logic              mem_done,
  output logic              mem_err,
  output logic              bus_err,
  output logic              BEN,
  output logic [DATA_W-1:0] MAR,
  output logic [DATA_W-1:0] MDR,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] IR,
  output logic [LED_W-1:0]  LED,
  output logic [31:0]       retired
);

  function automatic logic signed [DATA_W-1:0] sext(input logic [10:0] v, input int n);
    logic signed [DATA_W-1:0] r;
    r = {DATA_W{v[n-1]}};
    for (int i = 0; i < 11; i++)
      if (i < n) r[i] = v[i];
    return r;
  endfunction

  logic [DATA_W-1:0] regs [8];
  logic [2:0]        cc;
  logic [2:0]        sr1_idx, dr_idx;
  logic [DATA_W-1:0] sr1_val, sr2_val, alu_b, alu_out;
  logic [DATA_W-1:0] addr1, addr_sum, marmux_out, bus;
  logic signed [DATA_W-1:0] imm5_s, addr2_s;
  logic [3:0]        gates;
  logic              bus_conflict, mdr_cap;
  logic [2:0]        cc_nx;

  assign sr1_idx = SR1MUX ? IR[8:6] : IR[11:9];
  assign dr_idx  = DRMUX ? R7_IDX : IR[11:9];
  assign sr1_val = regs[sr1_idx];
  assign sr2_val = regs[IR[2:0]];
  assign imm5_s  = sext(IR[10:0], 5);
  assign alu_b   = SR2MUX ? imm5_s : sr2_val;

  always_comb begin
    alu_out = '0;
    case (aluk_t'(ALUK))
      ALU_ADD:  alu_out = sr1_val + alu_b;
      ALU_AND:  alu_out = sr1_val & alu_b;
      ALU_NOT:  alu_out = ~sr1_val;
      ALU_PASS: alu_out = sr1_val;
      default:  alu_out = '0;
    endcase
  end

  always_comb begin
    addr2_s = '0;
    case (addr2mux_t'(ADDR2MUX))
      A2_ZERO:  addr2_s = '0;
      A2_OFF6:  addr2_s = sext(IR[10:0], 6);
      A2_OFF9:  addr2_s = sext(IR[10:0], 9);
      A2_OFF11: addr2_s = sext(IR[10:0], 11);
      default:  addr2_s = '0;
    endcase
  end

  assign addr1      = ADDR1MUX ? sr1_val : PC;
  assign addr_sum   = addr1 + addr2_s;
  assign marmux_out = MARMUX ? {{(DATA_W-8){1'b0}}, IR[7:0]} : addr_sum;

  // Any gate pattern other than one-hot floats the bus to zero.
  assign gates        = {GatePC, GateMDR, GateALU, GateMARMUX};
  assign bus_conflict = (gates & (gates - 4'd1)) != 4'd0;

  always_comb begin
    bus = '0;
    case (gates)
      4'b1000: bus = PC;
      4'b0100: bus = MDR;
      4'b0010: bus = alu_out;
      4'b0001: bus = marmux_out;
      default: bus = '0;
    endcase
  end

  assign cc_nx = bus[DATA_W-1] ? CC_NEG : ((bus == '0) ? CC_ZERO : CC_POS);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      MAR     <= '0;
      MDR     <= '0;
      IR      <= '0;
      LED     <= '0;
      PC      <= PC_RESET;
      cc      <= 3'b000;
      BEN     <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if (LD_REG) regs[dr_idx] <= bus;
      if (LD_MAR) MAR <= bus;
      if (mdr_cap)     MDR <= mem_rdata;
      else if (LD_MDR) MDR <= bus;
      if (LD_IR)  IR  <= bus;
      if (LD_LED) LED <= IR[LED_W-1:0];
      if (LD_CC)  cc  <= cc_nx;
      if (LD_BEN) BEN <= |(IR[11:9] & cc);
      if (LD_PC) begin
        case (pcmux_t'(PCMUX))
          PC_INC:   PC <= PC + DATA_W'(1);
          PC_BUS:   PC <= bus;
          PC_ADDER: PC <= addr_sum;
          default:  PC <= PC;
        endcase
      end
      if (bus_conflict) bus_err <= 1'b1;
    end
  end

  slc3_mem_if #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_mem_if (
    .Clk      (Clk),
    .Reset    (Reset),
    .rd_start (mem_rd_start),
    .wr_start (mem_wr_start),
    .ack      (mem_ack),
    .req      (mem_req),
    .we       (mem_we),
    .busy     (mem_busy),
    .done     (mem_done),
    .err      (mem_err),
    .mdr_cap  (mdr_cap)
  );

`ifdef SLC3_DP_PERF_EN
  logic [31:0] retired_q;

  always_ff @(posedge Clk) begin
    if (!Reset)     retired_q <= '0;
    else if (LD_IR) retired_q <= retired_q + 32'd1;
  end

  assign retired = retired_q;
`else
  assign retired = '0;
`endif

endmodule

// File: tb/tb_slc3_datapath_hs.sv
// Directed bench for slc3_datapath_hs: reset, ALU/CC, memory handshake, timeout, bus conflict, PC paths.
module tb_slc3_datapath_hs;

  localparam int DW  = 16;
  localparam int LW  = 12;
  localparam int TO  = 15;
  localparam logic [DW-1:0] PCR = 16'h3000;
`ifdef SLC3_DP_PERF_EN
  localparam int RET5 = 5;
`else
  localparam int RET5 = 0;
`endif

  logic          Clk, Reset;
  logic          LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic          GatePC, GateMDR, GateALU, GateMARMUX;
  logic          SR2MUX, ADDR1MUX, MARMUX, DRMUX, SR1MUX;
  logic [1:0]    PCMUX, ADDR2MUX, ALUK;
  logic          mem_rd_start, mem_wr_start, mem_ack;
  logic [DW-1:0] mem_rdata;
  logic          mem_req, mem_we, mem_busy, mem_done, mem_err, bus_err, BEN;
  logic [DW-1:0] MAR, MDR, PC, IR;
  logic [LW-1:0] LED;
  logic [31:0]   retired;

  int passes = 0;
  int fails  = 0;
  int total  = 0;

  slc3_datapath_hs #(.DATA_W(DW), .LED_W(LW), .MEM_TIMEOUT(TO), .PC_RESET(PCR)) dut (
    .Clk(Clk), .Reset(Reset),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .SR2MUX(SR2MUX), .ADDR1MUX(ADDR1MUX), .MARMUX(MARMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX),
    .PCMUX(PCMUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .mem_rd_start(mem_rd_start), .mem_wr_start(mem_wr_start),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_busy(mem_busy), .mem_done(mem_done),
    .mem_err(mem_err), .bus_err(bus_err), .BEN(BEN),
    .MAR(MAR), .MDR(MDR), .PC(PC), .IR(IR), .LED(LED), .retired(retired)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic clr();
    {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = '0;
    {GatePC, GateMDR, GateALU, GateMARMUX} = '0;
    {SR2MUX, ADDR1MUX, MARMUX, DRMUX, SR1MUX} = '0;
    PCMUX = 2'd0; ADDR2MUX = 2'd0; ALUK = 2'd0;
    mem_rd_start = 1'b0; mem_wr_start = 1'b0; mem_ack = 1'b0;
  endtask

  initial begin
    clr();
    mem_rdata = '0;
    Reset = 1'b0;
    {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED} = '1;
    step();
    chk("rst_pc", 32'(PC), 'h3000);
    chk("rst_mar", 32'(MAR), 0);
    chk("rst_mdr", 32'(MDR), 0);
    chk("rst_ir", 32'(IR), 0);
    chk("rst_led", 32'(LED), 0);
    chk("rst_ben", 32'(BEN), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_busy", 32'(mem_busy), 0);
    chk("rst_err", 32'(mem_err), 0);
    chk("rst_buserr", 32'(bus_err), 0);
    chk("rst_retired", retired, 0);
    clr();
    Reset = 1'b1;

    // PC -> MAR, then minimum-latency read
    GatePC = 1; LD_MAR = 1; step(); clr();
    chk("mar_from_pc", 32'(MAR), 'h3000);
    mem_rd_start = 1; step(); clr();
    chk("rd0_req", 32'(mem_req), 1);
    chk("rd0_we", 32'(mem_we), 0);
    chk("rd0_busy", 32'(mem_busy), 1);
    mem_ack = 1; mem_rdata = 16'h127F; step(); mem_ack = 0;
    chk("rd0_mdr", 32'(MDR), 'h127F);
    chk("rd0_done", 32'(mem_done), 1);
    chk("rd0_req_off", 32'(mem_req), 0);
    step();
    chk("rd0_done_pulse", 32'(mem_done), 0);

    // ADD R1,R1,#-1
    GateMDR = 1; LD_IR = 1; step(); clr();
    chk("ir_127f", 32'(IR), 'h127F);
    SR2MUX = 1; ALUK = 2'd0; GateALU = 1; LD_REG = 1; LD_CC = 1; step(); clr();
    ALUK = 2'd3; GateALU = 1; LD_MAR = 1; LD_BEN = 1; step(); clr();
    chk("add_r1", 32'(MAR), 'hFFFF);
    chk("ben_p_vs_neg", 32'(BEN), 0);

    // Read with ack on the third request cycle
    GatePC = 1; LD_MAR = 1; step(); clr();
    mem_rd_start = 1; step(); clr();
    mem_rdata = 16'hBEEF;
    step();
    chk("rd1_wait_mdr", 32'(MDR), 'h127F);
    chk("rd1_wait_req", 32'(mem_req), 1);
    step();
    chk("rd1_wait_req2", 32'(mem_req), 1);
    mem_ack = 1; step(); mem_ack = 0;
    chk("rd1_mdr", 32'(MDR), 'hBEEF);
    chk("rd1_done", 32'(mem_done), 1);
    chk("rd1_err", 32'(mem_err), 0);
    step();
    chk("rd1_idle", 32'(mem_busy), 0);

    // IR=BEEF has nzp=111; CC is still negative from the ADD
    GateMDR = 1; LD_IR = 1; step(); clr();
    LD_BEN = 1; step(); clr();
    chk("ben_neg", 32'(BEN), 1);

    // Write leaves MDR alone even if rdata toggles
    mem_wr_start = 1; step(); clr();
    chk("wr_req", 32'(mem_req), 1);
    chk("wr_we", 32'(mem_we), 1);
    mem_ack = 1; mem_rdata = 16'h5555; step(); mem_ack = 0;
    chk("wr_mdr", 32'(MDR), 'hBEEF);
    chk("wr_done", 32'(mem_done), 1);
    step();

    // Timeout
    mem_rd_start = 1; step(); clr();
    for (int i = 0; i < TO - 1; i++) step();
    chk("to_last_req", 32'(mem_req), 1);
    chk("to_last_err", 32'(mem_err), 0);
    step();
    chk("to_done", 32'(mem_done), 1);
    chk("to_err", 32'(mem_err), 1);
    chk("to_req", 32'(mem_req), 0);
    chk("to_mdr", 32'(MDR), 'hBEEF);
    step();
    chk("to_idle", 32'(mem_busy), 0);
    mem_ack = 1; mem_rdata = 16'h1234; step(); mem_ack = 0;
    chk("ack_idle_ign", 32'(MDR), 'hBEEF);
    chk("ack_idle_busy", 32'(mem_busy), 0);

    // PC mux paths and address adder
    LD_PC = 1; PCMUX = 2'd0; step(); clr();
    chk("pc_inc", 32'(PC), 'h3001);
    LD_PC = 1; PCMUX = 2'd2; ADDR1MUX = 0; ADDR2MUX = 2'd3; step(); clr();
    chk("pc_off11", 32'(PC), 'h2EF0);
    LD_PC = 1; PCMUX = 2'd3; step(); clr();
    chk("pc_hold", 32'(PC), 'h2EF0);
    GateMARMUX = 1; MARMUX = 1; LD_PC = 1; PCMUX = 2'd1; LD_MAR = 1; step(); clr();
    chk("pc_bus", 32'(PC), 'h00EF);
    chk("mar_zext8", 32'(MAR), 'h00EF);
    GateMARMUX = 1; MARMUX = 0; ADDR1MUX = 1; SR1MUX = 1; ADDR2MUX = 2'd1; LD_MAR = 1; step(); clr();
    chk("mar_sr1_off6", 32'(MAR), 'hFFEF);
    LD_LED = 1; step(); clr();
    chk("led", 32'(LED), 'hEEF);

    // R7 via DRMUX, then AND imm / ADD reg / NOT
    GateMARMUX = 1; MARMUX = 1; LD_REG = 1; DRMUX = 1; step(); clr();
    ALUK = 2'd1; SR2MUX = 1; GateALU = 1; LD_MAR = 1; step(); clr();
    chk("and_imm", 32'(MAR), 'h000F);
    ALUK = 2'd0; SR2MUX = 0; GateALU = 1; LD_MAR = 1; step(); clr();
    chk("add_reg", 32'(MAR), 'h01DE);
    ALUK = 2'd2; GateALU = 1; LD_MAR = 1; step(); clr();
    chk("not_r7", 32'(MAR), 'hFF10);

    // Two gates at once
    GatePC = 1; GateMDR = 1; LD_MAR = 1; step(); clr();
    chk("conflict_bus", 32'(MAR), 0);
    chk("conflict_err", 32'(bus_err), 1);
    step();
    chk("conflict_sticky", 32'(bus_err), 1);

    // Three more fetches make five
    for (int i = 0; i < 3; i++) begin
      GateMDR = 1; LD_IR = 1; step(); clr();
    end
    chk("retired", retired, RET5);

    // Reset during a transaction
    mem_rd_start = 1; step(); clr();
    chk("mid_req", 32'(mem_req), 1);
    Reset = 1'b0; step(); Reset = 1'b1;
    chk("mid_rst_req", 32'(mem_req), 0);
    chk("mid_rst_err", 32'(mem_err), 0);
    chk("mid_rst_buserr", 32'(bus_err), 0);
    chk("mid_rst_pc", 32'(PC), 'h3000);
    chk("mid_rst_retired", retired, 0);

    // Both starts together
    mem_rd_start = 1; mem_wr_start = 1; step(); clr();
    chk("both_req", 32'(mem_req), 1);
    chk("both_we", 32'(mem_we), 0);
    chk("both_err", 32'(mem_err), 1);
    mem_ack = 1; mem_rdata = 16'hA5A5; step(); mem_ack = 0;
    chk("both_mdr", 32'(MDR), 'hA5A5);
    step();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
